// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: phase sequencer for the washer datapath with rinse repeat, cancel-to-drain,
// door wait timeout and a per-phase watchdog that traps stuck phases in FAULT.
module wash_cycle_controller #(
    parameter int RINSE_COUNT      = 2,
    parameter int WATCHDOG_CYCLES  = 64,
    parameter int DOOR_WAIT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       cold_wash,
    input  logic       door_closed,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       timer_clear,
    output logic       door_lock,
    output logic       water_valve,
    output logic       heater,
    output logic       motor,
    output logic       drain_pump,
    output logic       done,
    output logic       fault
);
    typedef enum logic [2:0] {
        IDLE, DOOR_CHECK, FILL_WATER, HEAT_WATER, WASH, RINSE, SPIN, FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] rinse_q, rinse_d;
    logic [7:0] wd_q, door_q;
    logic       cold_q, abort_q, abort_d, clear_q, clear_d, done_q, done_d;
    logic       active, next_active, comp, wd_hit, door_hit, reenter;

    assign active      = state_q >= FILL_WATER && state_q <= SPIN;
    assign next_active = state_d >= FILL_WATER && state_d <= SPIN;
    // flags are ignored on the entry cycle so a stale completion from the previous phase cannot leak through
    assign comp = !clear_q && (state_q == FILL_WATER ? sig_Full :
                               state_q == HEAT_WATER ? sig_Temperature :
                               (state_q >= WASH && state_q <= SPIN) ? sig_Completed : 1'b0);
    assign wd_hit   = active && wd_q == 8'(WATCHDOG_CYCLES - 1);
    assign door_hit = door_q == 8'(DOOR_WAIT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        rinse_d = rinse_q;
        abort_d = abort_q;
        reenter = 1'b0;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                rinse_d = 2'd0;
                state_d = (start && !cancel) ? DOOR_CHECK : IDLE;
            end
            DOOR_CHECK: state_d = cancel ? IDLE : door_closed ? FILL_WATER : door_hit ? IDLE : DOOR_CHECK;
            FILL_WATER, HEAT_WATER, WASH, RINSE: begin
                if (cancel) begin
                    state_d = SPIN;
                    abort_d = 1'b1;
                end else if (comp) begin
                    reenter = state_q == RINSE && rinse_q < 2'(RINSE_COUNT);
                    state_d = state_q == FILL_WATER ? (cold_q ? WASH : HEAT_WATER) :
                              state_q == HEAT_WATER ? WASH :
                              state_q == WASH ? RINSE : (reenter ? RINSE : SPIN);
                    rinse_d = state_q == WASH ? 2'd1 : reenter ? rinse_q + 2'd1 : rinse_q;
                end else if (wd_hit) begin
                    state_d = FAULT;
                end
            end
            SPIN:    state_d = comp ? IDLE : wd_hit ? FAULT : SPIN;
            FAULT:   state_d = cancel ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
        clear_d = next_active && (state_d != state_q || reenter);
        done_d  = state_q == SPIN && comp && !abort_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rinse_q <= 2'd0;
            wd_q    <= 8'd0;
            door_q  <= 8'd0;
            cold_q  <= 1'b0;
            abort_q <= 1'b0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
            abort_q <= abort_d;
            clear_q <= clear_d;
            done_q  <= done_d;
            wd_q    <= (clear_d || !next_active) ? 8'd0 : wd_q + 8'd1;
            door_q  <= (state_q == DOOR_CHECK && state_d == DOOR_CHECK) ? door_q + 8'd1 : 8'd0;
            if (state_q == IDLE && start && !cancel)
                cold_q <= cold_wash;
        end
    end

    assign state       = state_q;
    assign timer_clear = clear_q;
    assign done        = done_q;
    assign door_lock   = active;
    assign water_valve = state_q == FILL_WATER;
    assign heater      = state_q == HEAT_WATER;
    assign motor       = state_q >= WASH && state_q <= SPIN;
    assign drain_pump  = state_q == RINSE || state_q == SPIN;
    assign fault       = state_q == FAULT;
endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb_wash_cycle_controller: directed scenarios plus random stimulus against a phase/age reference model.
module tb_wash_cycle_controller;
    localparam int RC = 2, WD = 64, DW = 16;

    logic clock = 1'b0;
    logic reset, start, cancel, cold_wash, door_closed, sig_Full, sig_Temperature, sig_Completed;
    logic [2:0] state;
    logic timer_clear, door_lock, water_valve, heater, motor, drain_pump, done, fault;

    int n_cmp = 0, n_bad = 0;
    int m_phase = 0, m_age = 0, m_rinse = 0;
    bit m_cold = 0, m_abort = 0, m_done = 0, auto_flags = 0;
    int cnt_done, cnt_rinse_tc, cnt_heat, cnt_door, cnt_fill;

    always #5 clock = ~clock;

    wash_cycle_controller dut (
        .clock(clock), .reset(reset), .start(start), .cancel(cancel), .cold_wash(cold_wash),
        .door_closed(door_closed), .sig_Full(sig_Full), .sig_Temperature(sig_Temperature),
        .sig_Completed(sig_Completed), .state(state), .timer_clear(timer_clear), .door_lock(door_lock),
        .water_valve(water_valve), .heater(heater), .motor(motor), .drain_pump(drain_pump),
        .done(done), .fault(fault)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: current phase and how many cycles it has been occupied since entry.
    task automatic model_step();
        int np = m_phase;
        bit re = 0;
        bit q = m_age > 0;
        bit f = m_phase == 2 ? sig_Full : m_phase == 3 ? sig_Temperature : sig_Completed;
        bit wdog = m_age == WD - 1;
        m_done = 0;
        if (reset) begin
            m_phase = 0; m_age = 0; m_rinse = 0; m_cold = 0; m_abort = 0;
            return;
        end
        case (m_phase)
            0: if (start && !cancel) begin np = 1; m_cold = cold_wash; end
            1: if (cancel) np = 0; else if (door_closed) np = 2; else if (m_age == DW - 1) np = 0;
            2, 3, 4, 5: begin
                if (cancel) begin np = 6; m_abort = 1; end
                else if (f && q) begin
                    if (m_phase == 2) np = m_cold ? 4 : 3;
                    else if (m_phase == 3) np = 4;
                    else if (m_phase == 4) begin np = 5; m_rinse = 1; end
                    else if (m_rinse < RC) begin re = 1; m_rinse++; end
                    else np = 6;
                end else if (wdog) np = 7;
            end
            6: if (f && q) begin np = 0; m_done = !m_abort; end else if (wdog) np = 7;
            7: if (cancel) np = 0;
            default: np = 0;
        endcase
        m_age = (np != m_phase || re) ? 0 : m_age + 1;
        m_phase = np;
        if (np == 0) m_abort = 0;
    endtask

    function automatic logic [7:0] exp_outs();
        int p = m_phase;
        return {m_age == 0 && p >= 2 && p <= 6, p >= 2 && p <= 6, p == 2, p == 3,
                p >= 4 && p <= 6, p >= 5 && p <= 6, m_done, p == 7};
    endfunction

    task automatic step();
        if (auto_flags) begin
            sig_Full = m_age == 3;
            sig_Temperature = m_age == 3;
            sig_Completed = m_age == 3;
        end
        @(posedge clock);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_phase));
        chk("outs", 32'({timer_clear, door_lock, water_valve, heater, motor, drain_pump, done, fault}),
            32'(exp_outs()));
        cnt_done += int'(done);
        cnt_heat += int'(heater);
        if (state == 3'd5 && timer_clear) cnt_rinse_tc++;
        if (state == 3'd1) cnt_door++;
        if (state == 3'd2) cnt_fill++;
    endtask

    task automatic zero_counts();
        cnt_done = 0; cnt_rinse_tc = 0; cnt_heat = 0; cnt_door = 0; cnt_fill = 0;
    endtask

    task automatic run_until(int target, int bound);
        int n = 0;
        while (state !== 3'(target) && n < bound) begin
            step();
            n++;
        end
        chk("reach", 32'(state), 32'(target));
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    initial begin
        reset = 1; start = 0; cancel = 0; cold_wash = 0; door_closed = 0;
        sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
        zero_counts();
        step(); step();
        chk("reset_state", 32'(state), 32'd0);
        reset = 0;

        zero_counts(); door_closed = 1; auto_flags = 1;
        pulse_start();
        run_until(6, 200); run_until(0, 50);
        chk("hot_done", cnt_done, 1);
        chk("hot_rinse_tc", cnt_rinse_tc, RC);

        zero_counts(); cold_wash = 1;
        pulse_start(); cold_wash = 0;
        run_until(6, 200); run_until(0, 50);
        chk("cold_heater", cnt_heat, 0);
        chk("cold_done", cnt_done, 1);

        zero_counts(); door_closed = 0;
        pulse_start();
        run_until(0, 40);
        chk("door_wait", cnt_door, DW);

        zero_counts(); door_closed = 1;
        pulse_start();
        run_until(4, 100);
        auto_flags = 0; sig_Completed = 0;
        step(); step();
        cancel = 1; sig_Completed = 1;
        step();
        cancel = 0; sig_Completed = 0;
        chk("cancel_spin", 32'(state), 32'd6);
        auto_flags = 1;
        run_until(0, 50);
        chk("cancel_done", cnt_done, 0);

        zero_counts(); auto_flags = 0; sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
        pulse_start();
        run_until(7, 100);
        chk("wd_fill_cycles", cnt_fill, WD);
        start = 1; repeat (3) step(); start = 0;
        chk("fault_hold", 32'(state), 32'd7);
        cancel = 1; step(); cancel = 0;
        chk("fault_exit", 32'(state), 32'd0);

        zero_counts(); auto_flags = 1;
        pulse_start();
        run_until(3, 50);
        step();
        reset = 1; step(); reset = 0;
        chk("reset_heat", 32'({state, heater, door_lock}), 32'd0);
        pulse_start();
        chk("restart_door", 32'(state), 32'd1);
        run_until(6, 200); run_until(0, 50);
        chk("restart_done", cnt_done, 1);

        auto_flags = 0;
        repeat (3000) begin
            reset = $urandom_range(0, 199) == 0;
            start = $urandom_range(0, 3) == 0;
            cancel = $urandom_range(0, 29) == 0;
            cold_wash = 1'($urandom);
            door_closed = $urandom_range(0, 7) != 0;
            sig_Full = $urandom_range(0, 5) == 0;
            sig_Temperature = $urandom_range(0, 5) == 0;
            sig_Completed = $urandom_range(0, 5) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wash_cycle_controller.md
Name: wash_cycle_controller

Overview:
Top-level sequencer for the washing-machine datapath. It drives the 3-bit phase code into the phase timer and consumes the timer's completion flags (sig_Full, sig_Temperature, sig_Completed). It controls the actuator enables, the door lock, multi-rinse repetition, cancel/drain, and a per-phase watchdog that traps a stuck phase into FAULT.

Parameters:
RINSE_COUNT, 2, number of rinse passes per cycle; legal range 1..3.
WATCHDOG_CYCLES, 64, maximum cycles allowed in one phase before FAULT; legal range 8..255.
DOOR_WAIT_CYCLES, 16, cycles to wait in DOOR_CHECK for door_closed before returning to IDLE.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  level; begin a cycle when IDLE
cancel  in  1  level; abort an active cycle, or acknowledge FAULT
cold_wash  in  1  sampled on start; 1 = skip HEAT_WATER
door_closed  in  1  door sensor
sig_Full  in  1  fill phase complete
sig_Temperature  in  1  heat phase complete
sig_Completed  in  1  wash/rinse/spin phase complete
state  out  3  phase code: 0 IDLE, 1 DOOR_CHECK, 2 FILL_WATER, 3 HEAT_WATER, 4 WASH, 5 RINSE, 6 SPIN, 7 FAULT
timer_clear  out  1  one-cycle pulse on every phase entry, including rinse re-entry
door_lock  out  1  high in states 2..6
water_valve  out  1  high in FILL_WATER only
heater  out  1  high in HEAT_WATER only
motor  out  1  high in WASH, RINSE, SPIN
drain_pump  out  1  high in RINSE, SPIN
done  out  1  one-cycle pulse on normal completion of SPIN
fault  out  1  high in FAULT

Behaviour:
- Reset, which overrides all other inputs: state=IDLE. All outputs 0. Rinse counter, watchdog, door-wait counter and latched cold_wash all cleared. Reset mid-cycle drops every actuator on the next edge.
- All outputs are registered. Actuator, door_lock and fault decode from the registered state, so they change in the same cycle as state.
- IDLE: start=1 and cancel=0 -> DOOR_CHECK; latch cold_wash. start is ignored in any other state.
- DOOR_CHECK:
  - door_closed=1 -> FILL_WATER.
  - door-wait counter reaches DOOR_WAIT_CYCLES, or cancel=1 -> IDLE.
  - No done and no fault in either case.
- Phase entry, for any move into 2..6 (including RINSE->RINSE): timer_clear=1 for exactly the first cycle in the new phase. The watchdog resets to 0 on that cycle.
- Completion qualification: a flag counts only when timer_clear=0, so stale flags are ignored on the entry cycle.
  - FILL_WATER: sig_Full -> HEAT_WATER, or WASH if cold_wash was latched.
  - HEAT_WATER: sig_Temperature -> WASH.
  - WASH: sig_Completed -> RINSE; rinse counter=1.
  - RINSE: sig_Completed and counter<RINSE_COUNT -> re-enter RINSE; counter+1. sig_Completed and counter==RINSE_COUNT -> SPIN.
  - SPIN: sig_Completed -> IDLE; done=1 for one cycle, in the cycle state shows IDLE.
- Cancel:
  - In FILL_WATER, HEAT_WATER, WASH or RINSE: cancel=1 -> SPIN (drain and spin down). Completing that SPIN -> IDLE with done=0.
  - In SPIN: cancel is ignored.
  - If cancel and a qualified completion arrive in the same cycle, cancel wins, except in SPIN.
- Watchdog:
  - Counts each cycle in states 2..6 while no qualified completion is present.
  - When the count equals WATCHDOG_CYCLES-1 and no completion arrives that cycle -> FAULT.
  - A completion in that same cycle wins.
- FAULT: all actuators 0, door_lock=0, fault=1. Only cancel=1 (-> IDLE) or reset exits. start is ignored.
- An abort flag records that SPIN was entered through cancel. It clears in IDLE.
- No combinational path from inputs to outputs.

Test Plan:
- Hot cycle: reset, start=1 with cold_wash=0, door_closed=1, each flag asserted 3 cycles after its phase entry -> state 0,1,2,3,4,5,5,6,0. Two timer_clear pulses in RINSE. done pulses once. water_valve high only in state 2.
- Cold wash with RINSE_COUNT=1: cold_wash=1 -> no HEAT_WATER visit. heater never high. Exactly one RINSE pass.
- Door timeout: start with door_closed=0 -> IDLE after 16 cycles in DOOR_CHECK. door_lock stays 0.
- Cancel during WASH, same cycle as sig_Completed -> SPIN, not RINSE. Then sig_Completed -> IDLE with done=0.
- Watchdog: hold sig_Full=0 in FILL_WATER -> FAULT after 64 cycles with water_valve=0 and fault=1. start has no effect. cancel -> IDLE.
- Mid-cycle reset in HEAT_WATER -> next edge state=0, heater=0, door_lock=0. A following start begins from DOOR_CHECK with the rinse counter cleared.
